// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver constants (state codes, oversampling, majority indices, tick divider).
package uart_pkg;
  localparam int UART_OS = 8;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] MAJ_I0    = 3'd3;
  localparam logic [2:0] MAJ_I1    = 3'd4;
  localparam logic [2:0] MAJ_I2    = 3'd5;
  localparam logic [2:0] IDX_LAST  = 3'd7;
  function automatic int tick_div(input int clk_freq, input int baud);
    return clk_freq / (baud * UART_OS);
  endfunction
endpackage

// File: rtl/uart_os_tick.sv
// uart_os_tick: restartable 8x oversampling tick generator with 3-bit sample index.
module uart_os_tick #(
  parameter int TICK_DIV = 108
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  output logic       tick,
  output logic [2:0] idx
);
  logic [15:0] r_cnt;
  logic [2:0]  r_idx;
  assign tick = (r_cnt == 16'(TICK_DIV - 1));
  assign idx  = r_idx;
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else begin
      r_cnt <= tick ? '0 : r_cnt + 16'd1;
      if (tick) r_idx <= r_idx + 3'd1;
    end
  end
endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: 8x-oversampled UART receiver, majority vote, framing/overrun detection, valid/ready holding register.
// Optional even-parity checking and parity_err port when UART_RX_PARITY_EN is defined.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  input  logic       rx_en,
  output logic [7:0] d_out,
  output logic       d_valid,
  input  logic       d_ready,
  output logic       frame_err,
  output logic       overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);
  localparam int TICK_DIV = tick_div(CLK_FREQ, BAUD);
  logic [1:0] r_sync;
  logic [2:0] r_state;
  logic [7:0] r_shreg;
  logic [2:0] r_bit;
  logic [2:0] r_s;
  logic       w_rxs;
  logic       w_tick;
  logic [2:0] w_idx;
  logic       w_clr;
  logic       w_s2;
  logic       w_maj;
  logic       w_done;
`ifdef UART_RX_PARITY_EN
  logic       r_pbad;
`endif
  assign w_rxs  = r_sync[1];
  assign w_clr  = rx_en && r_state == ST_IDLE && !w_rxs;
  // At the last majority index the live line stands in for its not-yet-captured sample
  assign w_s2   = (w_idx == MAJ_I2) ? w_rxs : r_s[2];
  assign w_maj  = (r_s[0] & r_s[1]) | (r_s[0] & w_s2) | (r_s[1] & w_s2);
  assign w_done = rx_en && r_state == ST_STOP && w_tick && w_idx == MAJ_I2;
  uart_os_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (w_clr),
    .tick(w_tick),
    .idx (w_idx)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync    <= 2'b11;
      r_state   <= ST_IDLE;
      r_shreg   <= '0;
      r_bit     <= '0;
      r_s       <= '0;
      d_out     <= '0;
      d_valid   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_pbad     <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      r_sync    <= {r_sync[0], rx_in};
      frame_err <= w_done && !w_maj;
      overrun   <= w_done && d_valid && !d_ready;
`ifdef UART_RX_PARITY_EN
      parity_err <= w_done && r_pbad;
`endif
      if (w_tick && w_idx == MAJ_I0) r_s[0] <= w_rxs;
      if (w_tick && w_idx == MAJ_I1) r_s[1] <= w_rxs;
      if (w_tick && w_idx == MAJ_I2) r_s[2] <= w_rxs;
      if (!rx_en) r_state <= ST_IDLE;
      else
        case (r_state)
          ST_IDLE:
            if (!w_rxs) begin
              r_state <= ST_START;
              r_bit   <= '0;
            end
          ST_START:
            if (w_tick && w_idx == MAJ_I2 && w_maj) r_state <= ST_IDLE;
            else if (w_tick && w_idx == IDX_LAST) r_state <= ST_DATA;
          ST_DATA:
            if (w_tick && w_idx == IDX_LAST) begin
              r_shreg <= {w_maj, r_shreg[7:1]};
              r_bit   <= r_bit + 3'd1;
`ifdef UART_RX_PARITY_EN
              if (r_bit == 3'd7) r_state <= ST_PARITY;
`else
              if (r_bit == 3'd7) r_state <= ST_STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
          ST_PARITY:
            if (w_tick && w_idx == IDX_LAST) begin
              r_pbad  <= w_maj ^ (^r_shreg);
              r_state <= ST_STOP;
            end
`endif
          ST_STOP:
            if (w_tick && w_idx == MAJ_I2) r_state <= ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      if (w_done && (!d_valid || d_ready)) begin
        d_out   <= r_shreg;
        d_valid <= 1'b1;
      end else if (d_valid && d_ready) d_valid <= 1'b0;
    end
  end
endmodule
